// File: rtl/bus_timer_pkg.sv
// Shared register offsets, default window base and interrupt state encoding
// for the bus_timer peripheral.
package bus_timer_pkg;

  localparam logic [7:0] DEFAULT_BASE_ADDR = 8'hF0;

  localparam logic [7:0] OFF_VALUE    = 8'd0;
  localparam logic [7:0] OFF_INTERVAL = 8'd1;
  localparam logic [7:0] OFF_RESET    = 8'd2;
  localparam logic [7:0] OFF_IRQ_EN   = 8'd3;
  localparam logic [7:0] OFF_OVERRUN  = 8'd4;

  typedef enum logic {
    IRQ_IDLE,
    IRQ_PENDING
  } irq_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides CLK down to a one-cycle TICK every CLK_PER_TICK cycles (CLK_PER_TICK >= 2).
// CLR restarts the division from zero.
module tick_prescaler #(
  parameter int CLK_PER_TICK = 100000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic CLR,
  output logic TICK
);

  localparam int             W    = $clog2(CLK_PER_TICK);
  localparam logic [W-1:0]   LAST = W'(CLK_PER_TICK - 1);

  logic [W-1:0] count;

  assign TICK = (count == LAST);

  always_ff @(posedge CLK) begin
    if (RESET || CLR) begin
      count <= '0;
    end else if (TICK) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped tick timer on the shared 8-bit bus with a held interrupt raise/ack.
// Define BUS_TIMER_OVERRUN_EN to add the OVERRUN event counter at BASE+4.
//
// state       | meaning
// IRQ_IDLE    | no interrupt outstanding
// IRQ_PENDING | raise asserted, waiting for the processor's ack
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR     = DEFAULT_BASE_ADDR,
  parameter int         CLK_PER_TICK  = 100000,
  parameter logic [7:0] INIT_INTERVAL = 8'd100
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

`ifdef BUS_TIMER_OVERRUN_EN
  localparam logic [8:0] WINDOW = 9'd5;
`else
  localparam logic [8:0] WINDOW = 9'd4;
`endif

  logic [7:0]  offset, rd_mux, rd_data, interval, ivl_count;
  logic        in_window, wr, rd, timer_clr, tick, evt, set_irq, irq_en, rd_en;
  logic [31:0] tick_count;
  irq_state_t  state, state_next;

  assign offset    = BUS_ADDR - BASE_ADDR;
  assign in_window = ({1'b0, BUS_ADDR} >= {1'b0, BASE_ADDR}) &&
                     ({1'b0, BUS_ADDR} <  ({1'b0, BASE_ADDR} + WINDOW));
  assign wr        = BUS_WE && in_window;
  assign rd        = !BUS_WE && in_window;
  assign timer_clr = wr && (offset == OFF_RESET);

  tick_prescaler #(.CLK_PER_TICK(CLK_PER_TICK)) u_prescaler (
    .CLK  (CLK),
    .RESET(RESET),
    .CLR  (timer_clr),
    .TICK (tick)
  );

  // A timer reset landing on a tick edge swallows that tick and its event.
  assign evt     = tick && !timer_clr && (interval != 8'd0) && ((ivl_count + 8'd1) == interval);
  assign set_irq = evt && irq_en;

  always_ff @(posedge CLK) begin
    if (RESET || timer_clr) begin
      tick_count <= '0;
      ivl_count  <= '0;
    end else if (tick) begin
      tick_count <= tick_count + 32'd1;
      ivl_count  <= evt ? 8'd0 : ivl_count + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      interval <= INIT_INTERVAL;
      irq_en   <= 1'b1;
    end else if (wr) begin
      case (offset)
        OFF_INTERVAL: interval <= BUS_DATA;
        OFF_IRQ_EN:   irq_en   <= BUS_DATA[0];
        default:      ;
      endcase
    end
  end

`ifdef BUS_TIMER_OVERRUN_EN
  logic [7:0] overrun;

  // A clearing write beats a same-edge event.
  always_ff @(posedge CLK) begin
    if (RESET || (wr && (offset == OFF_OVERRUN))) begin
      overrun <= '0;
    end else if (evt && (state == IRQ_PENDING) && (overrun != 8'hFF)) begin
      overrun <= overrun + 8'd1;
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (offset)
      OFF_VALUE:    rd_mux = tick_count[7:0];
      OFF_INTERVAL: rd_mux = interval;
      OFF_IRQ_EN:   rd_mux = {7'b0, irq_en};
`ifdef BUS_TIMER_OVERRUN_EN
      OFF_OVERRUN:  rd_mux = overrun;
`endif
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_en   <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_en   <= rd;
      rd_data <= rd_mux;
    end
  end

  assign BUS_DATA = rd_en ? rd_data : 8'hzz;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IRQ_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Set beats ack on the same edge; further events while pending merge.
  always_comb begin
    state_next = state;
    case (state)
      IRQ_IDLE:    if (set_irq) state_next = IRQ_PENDING;
      IRQ_PENDING: if (BUS_INTERRUPT_ACK && !set_irq) state_next = IRQ_IDLE;
      default:     state_next = IRQ_IDLE;
    endcase
  end

  always_comb begin
    BUS_INTERRUPT_RAISE = (state == IRQ_PENDING);
  end

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer with CLK_PER_TICK=4 and INIT_INTERVAL=3.
// The bus is pulled high, so a released (high-Z) bus reads back as 8'hFF.
module tb_bus_timer;

  localparam logic [7:0] BASE     = 8'hF0;
  localparam logic [7:0] RELEASED = 8'hFF;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       we    = 1'b0;
  logic       ack   = 1'b0;
  logic       drive = 1'b0;
  logic [7:0] addr  = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic       raise;
  tri1  [7:0] bus_data;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  assign bus_data = drive ? wdata : 8'hzz;

  always #5 clk = ~clk;

  bus_timer #(
    .BASE_ADDR    (BASE),
    .CLK_PER_TICK (4),
    .INIT_INTERVAL(8'd3)
  ) dut (
    .CLK                (clk),
    .RESET              (reset),
    .BUS_DATA           (bus_data),
    .BUS_ADDR           (addr),
    .BUS_WE             (we),
    .BUS_INTERRUPT_RAISE(raise),
    .BUS_INTERRUPT_ACK  (ack)
  );

  // cyc counts rising edges since reset release; sampling happens on the falling edge.
  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; we = 1'b0; ack = 1'b0; drive = 1'b0; addr = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] addr_cyc,
                          output logic [7:0] data_cyc, output logic [7:0] after_cyc);
    addr = a; we = 1'b0;
    addr_cyc = bus_data;
    step();
    addr = 8'h00;
    data_cyc = bus_data;
    step();
    after_cyc = bus_data;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    addr = a; we = 1'b1; wdata = d; drive = 1'b1;
    step();
    we = 1'b0; drive = 1'b0; addr = 8'h00;
  endtask

  task automatic test_reset();
    logic [7:0] a, d, f;
    do_reset();
    vectors++; if (raise !== 1'b0) begin miscompares++; $display("FAIL reset_raise: got %b want 0", raise); end
    vectors++; if (bus_data !== RELEASED) begin miscompares++; $display("FAIL reset_bus: got %h want released", bus_data); end
    bus_read(BASE + 8'd1, a, d, f);
    vectors++; if (a !== RELEASED) begin miscompares++; $display("FAIL read_addr_cycle: got %h want released", a); end
    vectors++; if (d !== 8'h03) begin miscompares++; $display("FAIL read_interval_init: got %h want 03", d); end
    vectors++; if (f !== RELEASED) begin miscompares++; $display("FAIL read_after_cycle: got %h want released", f); end
    bus_read(BASE + 8'd3, a, d, f);
    vectors++; if (d !== 8'h01) begin miscompares++; $display("FAIL read_irq_en_init: got %h want 01", d); end
    bus_read(BASE + 8'd2, a, d, f);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL read_timer_reset_reg: got %h want 00", d); end
    bus_write(BASE + 8'd1, 8'h07);
    bus_read(BASE + 8'd1, a, d, f);
    vectors++; if (d !== 8'h07) begin miscompares++; $display("FAIL interval_writeback: got %h want 07", d); end
    // write lands on edge 10; the read samples the count after edge 10 -> 10/4 = 2 ticks
    bus_write(BASE + 8'd0, 8'h55);
    bus_read(BASE + 8'd0, a, d, f);
    vectors++; if (d !== 8'h02) begin miscompares++; $display("FAIL value_write_ignored: got %h want 02", d); end
  endtask

  task automatic test_interrupt_timing();
    int first, second;
    logic held;
    do_reset();
    first = -1;
    for (int i = 0; i < 40 && first < 0; i++) begin
      step();
      if (raise === 1'b1) first = cyc;
    end
    vectors++; if (first != 12) begin miscompares++; $display("FAIL first_rise: got cycle %0d want 12", first); end
    held = 1'b1;
    repeat (5) begin step(); if (raise !== 1'b1) held = 1'b0; end
    vectors++; if (held !== 1'b1) begin miscompares++; $display("FAIL raise_held: got %b want 1", held); end
    ack = 1'b1; step(); ack = 1'b0;
    vectors++; if (raise !== 1'b0) begin miscompares++; $display("FAIL ack_clears: got %b want 0", raise); end
    second = -1;
    for (int i = 0; i < 40 && second < 0; i++) begin
      step();
      if (raise === 1'b1) second = cyc;
    end
    vectors++; if ((second - first) != 12) begin miscompares++; $display("FAIL rise_period: got %0d want 12", second - first); end
  endtask

  task automatic test_ack_collision();
    int first;
    logic held;
    do_reset();
    first = -1;
    for (int i = 0; i < 40 && first < 0; i++) begin
      step();
      if (raise === 1'b1) first = cyc;
    end
    held = 1'b1;
    while (cyc < 23) begin step(); if (raise !== 1'b1) held = 1'b0; end
    // ack lands on edge 24, which is also the second event
    ack = 1'b1; step(); ack = 1'b0;
    if (raise !== 1'b1) held = 1'b0;
    step();
    if (raise !== 1'b1) held = 1'b0;
    vectors++; if (held !== 1'b1 || first != 12) begin miscompares++; $display("FAIL ack_event_collide: got held=%b rise=%0d want held=1 rise=12", held, first); end
    ack = 1'b1; step(); ack = 1'b0;
    vectors++; if (raise !== 1'b0) begin miscompares++; $display("FAIL collide_then_ack: got %b want 0", raise); end
  endtask

  task automatic test_irq_en_hold();
    logic [7:0] a, d, f;
    logic seen;
    do_reset();
    while (cyc < 12) step();
    bus_write(BASE + 8'd3, 8'h00);
    repeat (3) step();
    vectors++; if (raise !== 1'b1) begin miscompares++; $display("FAIL en_clear_keeps_pending: got %b want 1", raise); end
    ack = 1'b1; step(); ack = 1'b0;
    seen = 1'b0;
    while (cyc < 40) begin step(); if (raise !== 1'b0) seen = 1'b1; end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL disabled_events_dropped: got %b want 0", seen); end
    bus_read(BASE + 8'd3, a, d, f);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL irq_en_readback: got %h want 00", d); end
  endtask

  task automatic test_interval_zero();
    logic [7:0] a, d, f;
    logic seen;
    do_reset();
    bus_write(BASE + 8'd1, 8'h00);
    seen = 1'b0;
    while (cyc < 101) begin step(); if (raise !== 1'b0) seen = 1'b1; end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL interval_zero_no_raise: got %b want 0", seen); end
    // count after edge 101 = 101/4 = 25 ticks
    bus_read(BASE + 8'd0, a, d, f);
    vectors++; if (d !== 8'd25) begin miscompares++; $display("FAIL tick_count_25: got %0d want 25", d); end
  endtask

  task automatic test_timer_reset();
    logic [7:0] a, d, f;
    logic seen;
    do_reset();
    bus_write(BASE + 8'd3, 8'h00);
    seen = 1'b0;
    repeat (20) begin step(); if (raise !== 1'b0) seen = 1'b1; end
    bus_write(BASE + 8'd2, 8'hA5);                 // clear on edge 22
    bus_read(BASE + 8'd0, a, d, f);                // sampled at edge 23
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL value_after_clear: got %h want 00", d); end
    bus_read(BASE + 8'd0, a, d, f);                // edge 25: prescaler restarted, no tick yet
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL prescaler_cleared: got %h want 00", d); end
    bus_read(BASE + 8'd0, a, d, f);                // edge 27: tick on edge 26
    vectors++; if (d !== 8'h01) begin miscompares++; $display("FAIL first_tick_after_clear: got %h want 01", d); end
    step();
    bus_write(BASE + 8'd2, 8'h00);                 // edge 30 coincides with a tick
    bus_read(BASE + 8'd0, a, d, f);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL clear_beats_tick: got %h want 00", d); end
    if (raise !== 1'b0) seen = 1'b1;
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL no_raise_when_disabled: got %b want 0", seen); end
    bus_read(8'hEF, a, d, f);
    vectors++; if ({a, d, f} !== {3{RELEASED}}) begin miscompares++; $display("FAIL below_window_hiz: got %h want released", {a, d, f}); end
    bus_read(8'hF5, a, d, f);
    vectors++; if ({a, d, f} !== {3{RELEASED}}) begin miscompares++; $display("FAIL above_window_hiz: got %h want released", {a, d, f}); end
  endtask

  task automatic test_reset_midway();
    do_reset();
    while (cyc < 12) step();
    addr = BASE + 8'd1; we = 1'b0;
    step();                                        // read registered; bus driven now
    vectors++; if (bus_data !== 8'h03) begin miscompares++; $display("FAIL pre_reset_drive: got %h want 03", bus_data); end
    reset = 1'b1;
    step();
    reset = 1'b0; addr = 8'h00;
    vectors++; if (bus_data !== RELEASED || raise !== 1'b0) begin miscompares++; $display("FAIL reset_midway: got bus=%h raise=%b want released/0", bus_data, raise); end
  endtask

  task automatic test_overrun();
    logic [7:0] a, d, f;
    do_reset();
`ifdef BUS_TIMER_OVERRUN_EN
    while (cyc < 37) step();                       // events at 12 (sets), 24 and 36 (overrun)
    bus_read(BASE + 8'd4, a, d, f);
    vectors++; if (d !== 8'd2) begin miscompares++; $display("FAIL overrun_count: got %0d want 2", d); end
    bus_write(BASE + 8'd4, 8'h5A);
    bus_read(BASE + 8'd4, a, d, f);
    vectors++; if (d !== 8'd0) begin miscompares++; $display("FAIL overrun_cleared: got %0d want 0", d); end
`else
    bus_read(BASE + 8'd4, a, d, f);
    vectors++; if ({a, d, f} !== {3{RELEASED}}) begin miscompares++; $display("FAIL offset4_hiz: got %h want released", {a, d, f}); end
`endif
  endtask

  initial begin
    test_reset();
    test_interrupt_timing();
    test_ack_collision();
    test_irq_en_hold();
    test_interval_zero();
    test_timer_reset();
    test_reset_midway();
    test_overrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
